// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared FSM state and requester-id definitions for add_sched
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/FA_22bit.sv
// rtl/FA_22bit.sv - parameterised ripple-carry adder, operands indexed [width:1]
module FA_22bit #(
    parameter int width = 22
) (
    input  logic [width:1] a,
    input  logic [width:1] b,
    input  logic           cin,
    output logic [width:1] sum,
    output logic           cout
);

    logic [width+1:1] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[1] = cin;
        for (int i = 1; i <= width; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[width+1];

endmodule

// File: rtl/add_sched_rr_arb.sv
// rtl/add_sched_rr_arb.sv - round-robin grant with burst lock for the shared adder
module add_sched_rr_arb
    import add_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic req0_last,
    input  logic req1_last,
    input  logic fire0,
    input  logic fire1,
    output logic grant0,
    output logic grant1,
    output logic in_burst
);

    state_t state;
    logic   ptr;

    // Lock overrides fairness; in IDLE a lone requester wins, a tie goes to ptr.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: begin
                grant0 = req0_valid & (~req1_valid | (ptr == REQ_ID0));
                grant1 = req1_valid & (~req0_valid | (ptr == REQ_ID1));
            end
        endcase
    end

    assign in_burst = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= REQ_ID0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire0) begin
                        if (req0_last) ptr   <= REQ_ID1;
                        else           state <= LOCK0;
                    end else if (fire1) begin
                        if (req1_last) ptr   <= REQ_ID0;
                        else           state <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (fire0 && req0_last) begin
                        state <= IDLE;
                        ptr   <= REQ_ID1;
                    end
                end
                LOCK1: begin
                    if (fire1 && req1_last) begin
                        state <= IDLE;
                        ptr   <= REQ_ID0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/add_sched.sv
// rtl/add_sched.sv - two-requester multi-word adder scheduler; optional ADD_SCHED_SAT_EN saturates final beats
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [WIDTH:1] req0_a,
    input  logic [WIDTH:1] req0_b,
    input  logic           req0_last,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [WIDTH:1] req1_a,
    input  logic [WIDTH:1] req1_b,
    input  logic           req1_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:1] out_sum,
    output logic           out_cout,
    output logic           out_id,
    output logic           out_last
);

    logic           grant0;
    logic           grant1;
    logic           in_burst;
    logic           space;
    logic           fire0;
    logic           fire1;
    logic           fire;
    logic           sel_id;
    logic           sel_last;
    logic           cin;
    logic           chain_carry;
    logic           add_cout;
    logic [WIDTH:1] sel_a;
    logic [WIDTH:1] sel_b;
    logic [WIDTH:1] add_sum;
    logic [WIDTH:1] next_sum;

    add_sched_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_last  (req0_last),
        .req1_last  (req1_last),
        .fire0      (fire0),
        .fire1      (fire1),
        .grant0     (grant0),
        .grant1     (grant1),
        .in_burst   (in_burst)
    );

    // The output register is free when empty or being drained this cycle.
    assign space      = ~out_valid | out_ready;
    assign req0_ready = rst_n & grant0 & space;
    assign req1_ready = rst_n & grant1 & space;
    assign fire0      = req0_valid & req0_ready;
    assign fire1      = req1_valid & req1_ready;
    assign fire       = fire0 | fire1;

    assign sel_id   = grant1 ? REQ_ID1 : REQ_ID0;
    assign sel_a    = grant1 ? req1_a : req0_a;
    assign sel_b    = grant1 ? req1_b : req0_b;
    assign sel_last = grant1 ? req1_last : req0_last;
    assign cin      = in_burst & chain_carry;

    FA_22bit #(
        .width (WIDTH)
    ) u_adder (
        .a    (sel_a),
        .b    (sel_b),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ADD_SCHED_SAT_EN
    assign next_sum = (sel_last & add_cout) ? '1 : add_sum;
`else
    assign next_sum = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_cout    <= 1'b0;
            out_id      <= REQ_ID0;
            out_last    <= 1'b0;
            chain_carry <= 1'b0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            out_sum     <= next_sum;
            out_cout    <= add_cout;
            out_id      <= sel_id;
            out_last    <= sel_last;
            chain_carry <= sel_last ? 1'b0 : add_cout;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - randomized and directed checks of add_sched against a behavioural model
module tb_add_sched;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   pv;
    logic [1:0]   pl;
    logic [W:1]   pa [2];
    logic [W:1]   pb [2];
    logic         out_ready;
    logic         req0_ready;
    logic         req1_ready;
    logic         out_valid;
    logic [W:1]   out_sum;
    logic         out_cout;
    logic         out_id;
    logic         out_last;

    always #5 clk = ~clk;

    add_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (pv[0]),
        .req0_ready (req0_ready),
        .req0_a     (pa[0]),
        .req0_b     (pb[0]),
        .req0_last  (pl[0]),
        .req1_valid (pv[1]),
        .req1_ready (req1_ready),
        .req1_a     (pa[1]),
        .req1_b     (pb[1]),
        .req1_last  (pl[1]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_id     (out_id),
        .out_last   (out_last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: burst owner (-1 none), fairness pointer, burst carry, output register.
    int         m_owner;
    logic       m_ptr;
    logic       m_carry;
    logic       m_ov;
    logic [W:1] m_sum;
    logic       m_cout;
    logic       m_id;
    logic       m_last;
    logic [1:0] fired;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 1'b0;
        m_carry = 1'b0;
        m_ov    = 1'b0;
        m_sum   = '0;
        m_cout  = 1'b0;
        m_id    = 1'b0;
        m_last  = 1'b0;
    endtask

    task automatic step();
        logic [1:0] g;
        logic [1:0] er;
        logic       space;
        logic       c_in;
        logic [W:0] full;
        int         n;
        @(negedge clk);
        fired = 2'b00;
        if (!rst_n) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_cout", out_cout, 0);
            chk("rst_out_id", out_id, 0);
            chk("rst_out_last", out_last, 0);
            model_reset();
        end else begin
            space = !m_ov || out_ready;
            g = 2'b00;
            if (m_owner >= 0)    g[m_owner] = 1'b1;
            else if (pv == 2'b11) g[m_ptr] = 1'b1;
            else                  g = pv;
            er = g & {2{space}};
            chk("req0_ready", req0_ready, er[0]);
            chk("req1_ready", req1_ready, er[1]);
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_cout", out_cout, m_cout);
                chk("out_id", out_id, m_id);
                chk("out_last", out_last, m_last);
            end
            n = -1;
            if (pv[0] && er[0])      n = 0;
            else if (pv[1] && er[1]) n = 1;
            if (n >= 0) begin
                c_in = (m_owner == n) ? m_carry : 1'b0;
                full = {1'b0, pa[n]} + {1'b0, pb[n]} + {{W{1'b0}}, c_in};
                m_sum  = full[W-1:0];
`ifdef ADD_SCHED_SAT_EN
                if (pl[n] && full[W]) m_sum = '1;
`endif
                m_cout = full[W];
                m_id   = n[0];
                m_last = pl[n];
                m_ov   = 1'b1;
                if (pl[n]) begin
                    m_owner = -1;
                    m_ptr   = ~n[0];
                    m_carry = 1'b0;
                end else begin
                    m_owner = n;
                    m_carry = full[W];
                end
                fired[n] = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (fired[0]) pv[0] = 1'b0;
        if (fired[1]) pv[1] = 1'b0;
    endtask

    task automatic beat(input int n, input logic [W:1] a, input logic [W:1] b, input logic last);
        pa[n] = a;
        pb[n] = b;
        pl[n] = last;
        pv[n] = 1'b1;
    endtask

    function automatic logic [W:1] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return 1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W:1] held;
        int         beats;
        rst_n = 1'b0;
        pv = 2'b11;
        pl = 2'b00;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        out_ready = 1'b1;
        model_reset();

        step();
        step();
        pv = 2'b00;
        rst_n = 1'b1;
        step();

        // Single beat with carry-out.
        beat(0, 22'h000001, 22'h3FFFFF, 1'b1);
        step();
`ifdef ADD_SCHED_SAT_EN
        chk("r32_sum", out_sum, 22'h3FFFFF);
`else
        chk("r32_sum", out_sum, 22'h000000);
`endif
        chk("r32_cout", out_cout, 1);
        chk("r32_id", out_id, 0);
        chk("r32_last", out_last, 1);
        step();
        chk("r32_drained", out_valid, 0);

        // Two-word burst carries between beats.
        beat(1, 22'h3FFFFF, 22'h000001, 1'b0);
        step();
        chk("r33_sum0", out_sum, 22'h000000);
        chk("r33_cout0", out_cout, 1);
        beat(1, 22'h000000, 22'h000000, 1'b1);
        step();
        chk("r33_sum1", out_sum, 22'h000001);
        chk("r33_cout1", out_cout, 0);
        chk("r33_id1", out_id, 1);
        step();

        // Alternation under continuous contention.
        for (int i = 0; i < 6; i++) begin
            if (!pv[0]) beat(0, W'(i), 22'h1, 1'b1);
            if (!pv[1]) beat(1, W'(i), 22'h2, 1'b1);
            step();
            chk("r34_id", out_id, i % 2);
        end
        pv = 2'b00;
        step();

        // Locked burst blocks the other requester until its last beat.
        beat(1, 22'h5, 22'h5, 1'b1);
        beat(0, 22'h3FFFFF, 22'h3FFFFF, 1'b0);
        step();
        chk("r35_sum0", out_sum, 22'h3FFFFE);
        chk("r35_lock_r1a", req1_ready, 0);
        beat(0, 22'h1, 22'h0, 1'b0);
        step();
        chk("r35_sum1", out_sum, 22'h000002);
        chk("r35_lock_r1b", req1_ready, 0);
        beat(0, 22'h0, 22'h0, 1'b1);
        step();
        chk("r35_id2", out_id, 0);
        chk("r35_last2", out_last, 1);
        chk("r35_r1_granted", req1_ready, 1);
        step();
        chk("r35_id3", out_id, 1);
        chk("r35_sum3", out_sum, 22'h00000A);

        // Backpressure holds the output and blocks both requesters.
        beat(0, 22'h11, 22'h22, 1'b1);
        beat(1, 22'h33, 22'h44, 1'b1);
        step();
        held = out_sum;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r36_hold_sum", out_sum, held);
            chk("r36_hold_valid", out_valid, 1);
            chk("r36_r0_blocked", req0_ready, 0);
            chk("r36_r1_blocked", req1_ready, 0);
        end
        out_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            if (!pv[0]) beat(0, W'(i), 22'h1, 1'b1);
            if (!pv[1]) beat(1, W'(i), 22'h3, 1'b1);
            step();
            if (out_valid) beats++;
        end
        chk("r36_resume_beats", beats, 4);
        pv = 2'b00;
        step();

        // Reset mid-burst discards carry.
        beat(0, 22'h3FFFFF, 22'h000001, 1'b0);
        step();
        chk("r37_loaded", out_valid, 1);
        rst_n = 1'b0;
        pv = 2'b00;
        step();
        chk("r37_rst_valid", out_valid, 0);
        rst_n = 1'b1;
        beat(0, 22'h1, 22'h1, 1'b1);
        step();
        chk("r37_sum", out_sum, 22'h000002);
        chk("r37_cout", out_cout, 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++)
                if (!pv[n] && $urandom_range(0, 3) != 0)
                    beat(n, rnd_val(), rnd_val(), $urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter WIDTH, default 22, operand/sum width in bits; all data buses are indexed [WIDTH:1].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 beat valid.
REQ-005 req0_ready  output  1  requester 0 beat accepted when valid&ready.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_last  input  1  final beat of a requester-0 multi-word burst.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_last  as REQ-004..007, requester 1.
REQ-009 out_valid  output  1  result register holds valid beat.
REQ-010 out_ready  input  1  downstream accepts result when out_valid&out_ready.
REQ-011 out_sum  output  WIDTH  beat sum.
REQ-012 out_cout  output  1  beat carry-out.
REQ-013 out_id  output  1  requester that issued the beat.
REQ-014 out_last  output  1  copy of accepted beat's last flag.

Function
REQ-015 Block shares one WIDTH-bit ripple adder between two requesters; low word first in a burst.
REQ-016 FSM states IDLE, LOCK0, LOCK1; IDLE->LOCKn on acceptance of a non-last beat from n; LOCKn->IDLE on acceptance of n's last beat; single-beat burst (last=1) in IDLE stays IDLE.
REQ-017 IDLE grant: only one valid -> that requester; both valid -> requester equal to round-robin pointer.
REQ-018 Pointer resets to 0; on completion (last beat accepted) pointer becomes the other requester.
REQ-019 In LOCKn only requester n is granted; other requester's ready is 0 regardless of its valid.
REQ-020 reqN_ready = granted(N) & (~out_valid | out_ready); combinational path out_ready->reqN_ready permitted.
REQ-021 Carry-in is 0 for first beat of a burst, registered cout of previous beat of the same burst otherwise.
REQ-022 On acceptance, next edge loads out_sum = a+b+cin mod 2^WIDTH, out_cout = carry, out_id, out_last, out_valid=1: latency 1 cycle.
REQ-023 Output held stable while out_valid & ~out_ready.
REQ-024 Output drained with no new beat -> out_valid=0 next cycle; drain and accept same cycle -> new beat loaded, throughput 1 beat/cycle.
REQ-025 Valid low mid-burst: FSM stays LOCKn, carry retained indefinitely.

Reset
REQ-026 rst_n low: state IDLE, pointer 0, chain carry 0, out_valid 0, out_sum 0, out_cout 0, out_id 0, out_last 0, both ready 0 while in reset.
REQ-027 Reset mid-burst discards the burst; first beat after reset uses carry-in 0.

Configuration
REQ-028 Macro ADD_SCHED_SAT_EN defined: beat with last=1 and carry-out 1 loads out_sum all-ones, out_cout 1; non-last beats unaffected.
REQ-029 Macro undefined: out_sum always wraps modulo 2^WIDTH; no saturation logic present.

Structure
REQ-030 Shared package add_sched_pkg holds FSM state enum (IDLE, LOCK0, LOCK1) and requester-id constants REQ_ID0=0, REQ_ID1=1.
REQ-031 Adder instantiated as the codebase's FA_22bit with width=WIDTH; grant logic in sub-module add_sched_rr_arb (pointer, lock state, grant outputs).

Verification
REQ-032 req0 single beat a=0x000001 b=0x3FFFFF last=1, out_ready=1 -> next cycle out_sum=0x000000 out_cout=1 out_id=0 out_last=1 (0x3FFFFF with ADD_SCHED_SAT_EN).
REQ-033 req1 burst: beat a=0x3FFFFF b=0x000001 last=0 -> sum 0x000000 cout 1; beat a=0 b=0 last=1 -> sum 0x000001 cout 0 id=1.
REQ-034 Both requesters valid continuously with single-beat bursts -> out_id sequence 0,1,0,1,...
REQ-035 req0 3-beat burst while req1 valid throughout -> req1_ready 0 until req0 last accepted, req1 granted next cycle.
REQ-036 out_ready low 3 cycles with out_valid=1 -> out_* stable, both ready 0; release -> one beat/cycle resumes.
REQ-037 rst_n pulsed after first non-last beat -> out_valid 0, FSM IDLE; next beat a=1 b=1 -> out_sum=0x000002.
